// File: rtl/board_pkg.sv
// Shared board definitions: geometry, cell status codes and response codes.
// Used by the status controller, its RAM and the VGA driver.
package board_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 10;
    localparam int CELLS   = BOARD_W * BOARD_H;
    localparam int AW      = 7;

    localparam logic [4:0] ST_FREE       = 5'd0;
    localparam logic [4:0] ST_OCC        = 5'd1;
    localparam logic [4:0] ST_PLAYER_HIT = 5'd2;
    localparam logic [4:0] ST_IA_HIT     = 5'd3;
    localparam logic [4:0] ST_BOTH_HIT   = 5'd4;

    localparam logic [1:0] RSP_MISS   = 2'd0;
    localparam logic [1:0] RSP_HIT    = 2'd1;
    localparam logic [1:0] RSP_REPEAT = 2'd2;
    localparam logic [1:0] RSP_BAD    = 2'd3;

    typedef enum logic [1:0] {
        CTL_CLEAR,
        CTL_IDLE,
        CTL_RMW
    } ctl_state_t;

    typedef enum logic [1:0] {
        SRC_SETUP,
        SRC_PLAYER,
        SRC_IA
    } src_t;

    typedef struct packed {
        logic [4:0] status;
        logic [1:0] resp;
    } rmw_t;

    function automatic logic [AW-1:0] cell_addr(input logic [3:0] x,
                                                 input logic [3:0] y);
        return AW'(y) * AW'(BOARD_W) + AW'(x);
    endfunction

    function automatic logic in_range(input logic [3:0] x,
                                      input logic [3:0] y);
        return (x < 4'(BOARD_W)) && (y < 4'(BOARD_H));
    endfunction

    // Unknown codes read back from memory count as an empty cell.
    function automatic logic [4:0] sanitize(input logic [4:0] s);
        return (s > ST_BOTH_HIT) ? ST_FREE : s;
    endfunction

    function automatic rmw_t rmw_rule(input src_t src,
                                      input logic [4:0] raw);
        logic [4:0] cur;
        rmw_t r;
        cur = sanitize(raw);
        r.status = cur;
        r.resp = RSP_REPEAT;
        case (src)
            SRC_SETUP: begin
                if (cur == ST_FREE) r = '{ST_OCC, RSP_MISS};
            end
            SRC_PLAYER: begin
                case (cur)
                    ST_FREE:   r = '{ST_PLAYER_HIT, RSP_MISS};
                    ST_OCC:    r = '{ST_PLAYER_HIT, RSP_HIT};
                    ST_IA_HIT: r = '{ST_BOTH_HIT, RSP_MISS};
                    default:   r.resp = RSP_REPEAT;
                endcase
            end
            SRC_IA: begin
                case (cur)
                    ST_FREE:       r = '{ST_IA_HIT, RSP_MISS};
                    ST_OCC:        r = '{ST_IA_HIT, RSP_HIT};
                    ST_PLAYER_HIT: r = '{ST_BOTH_HIT, RSP_MISS};
                    default:       r.resp = RSP_REPEAT;
                endcase
            end
            default: r.resp = RSP_REPEAT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/board_status_ctrl_if.sv
// Game-side request/ack bundle of the board status controller.
// master = game logic, slave = board_status_ctrl.
interface board_status_ctrl_if;

    logic       new_game;
    logic       ready;
    logic       setup_req;
    logic       player_req;
    logic       ia_req;
    logic [3:0] setup_x;
    logic [3:0] setup_y;
    logic [3:0] player_x;
    logic [3:0] player_y;
    logic [3:0] ia_x;
    logic [3:0] ia_y;
    logic       setup_ack;
    logic       player_ack;
    logic       ia_ack;
    logic [1:0] resp;

    modport master (
        output new_game, setup_req, player_req, ia_req,
        output setup_x, setup_y, player_x, player_y, ia_x, ia_y,
        input  ready, setup_ack, player_ack, ia_ack, resp
    );

    modport slave (
        input  new_game, setup_req, player_req, ia_req,
        input  setup_x, setup_y, player_x, player_y, ia_x, ia_y,
        output ready, setup_ack, player_ack, ia_ack, resp
    );

endinterface

// File: rtl/board_ram.sv
// 100x5 dual-port board RAM, synchronous read on both ports.
// Port A: clear/RMW read-write. Port B: VGA read-only.
module board_ram
    import board_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [4:0]    a_wdata,
    output logic [4:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [4:0]    b_rdata
);

    logic [4:0] mem [CELLS];

    // Port A write; port B reads in the same cycle see the old value.
    always_ff @(posedge clk_in) begin
        if (a_en && a_we) mem[a_addr] <= a_wdata;
    end

    // Port A registered read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) a_rdata <= ST_FREE;
        else if (a_en) a_rdata <= mem[a_addr];
    end

    // Port B registered read, every cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) b_rdata <= ST_FREE;
        else b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/board_status_ctrl.sv
// Board status owner: clear sweep, setup/player/IA read-modify-write
// arbitration and a never-stalled VGA read port.
module board_status_ctrl
    import board_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [3:0]         vga_cell_x,
    input  logic [3:0]         vga_cell_y,
    output logic [4:0]         vga_cell_status,
    board_status_ctrl_if.slave bus
);

    ctl_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    src_t          src_q, src_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          bad_q, bad_d;
    logic          rr_ia_q, rr_ia_d;
    logic [1:0]    resp_q, resp_d;
    logic          a_en, a_we;
    logic [AW-1:0] a_addr;
    logic [4:0]    a_wdata, a_rdata, b_rdata;
    logic          ack_any, req_any;
    src_t          sel_src;
    logic [3:0]    sel_x, sel_y;
    rmw_t          rule;
    logic          vga_bad_q, vga_clr_q;

    board_ram u_ram (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .a_en     (a_en),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .b_addr   (cell_addr(vga_cell_x, vga_cell_y)),
        .b_rdata  (b_rdata)
    );

    assign req_any = bus.setup_req | bus.player_req | bus.ia_req;

    // Winner select: setup first, then player/IA with last-served losing ties.
    always_comb begin
        sel_src = SRC_IA;
        sel_x = bus.ia_x;
        sel_y = bus.ia_y;
        if (bus.setup_req) begin
            sel_src = SRC_SETUP;
            sel_x = bus.setup_x;
            sel_y = bus.setup_y;
        end else if (bus.player_req && (!bus.ia_req || !rr_ia_q)) begin
            sel_src = SRC_PLAYER;
            sel_x = bus.player_x;
            sel_y = bus.player_y;
        end
    end

    // Next state, RAM port A control and ack/resp generation.
    always_comb begin
        state_d = state_q;
        clr_cnt_d = clr_cnt_q;
        src_d = src_q;
        addr_d = addr_q;
        bad_d = bad_q;
        rr_ia_d = rr_ia_q;
        resp_d = resp_q;
        a_en = 1'b0;
        a_we = 1'b0;
        a_addr = addr_q;
        a_wdata = ST_FREE;
        ack_any = 1'b0;
        rule = rmw_rule(src_q, a_rdata);
        unique case (state_q)
            CTL_CLEAR: begin
                a_en = 1'b1;
                a_we = 1'b1;
                a_addr = clr_cnt_q;
                if (bus.new_game) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == AW'(CELLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d = CTL_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            CTL_IDLE: begin
                if (bus.new_game) begin
                    state_d = CTL_CLEAR;
                    clr_cnt_d = '0;
                end else if (req_any) begin
                    src_d = sel_src;
                    bad_d = !in_range(sel_x, sel_y);
                    addr_d = cell_addr(sel_x, sel_y);
                    a_en = !bad_d;
                    a_addr = addr_d;
                    state_d = CTL_RMW;
                    if (sel_src == SRC_PLAYER) rr_ia_d = 1'b1;
                    else if (sel_src == SRC_IA) rr_ia_d = 1'b0;
                end
            end
            CTL_RMW: begin
                if (bus.new_game) begin
                    state_d = CTL_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    ack_any = 1'b1;
                    state_d = CTL_IDLE;
                    a_en = !bad_q;
                    a_we = !bad_q;
                    a_wdata = rule.status;
                    resp_d = bad_q ? RSP_BAD : rule.resp;
                end
            end
            default: state_d = CTL_CLEAR;
        endcase
    end

    // Controller state and latched grant.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= CTL_CLEAR;
            clr_cnt_q <= '0;
            src_q <= SRC_SETUP;
            addr_q <= '0;
            bad_q <= 1'b0;
            rr_ia_q <= 1'b0;
            resp_q <= RSP_MISS;
        end else begin
            state_q <= state_d;
            clr_cnt_q <= clr_cnt_d;
            src_q <= src_d;
            addr_q <= addr_d;
            bad_q <= bad_d;
            rr_ia_q <= rr_ia_d;
            resp_q <= resp_d;
        end
    end

    // VGA masking flags aligned with the one-cycle RAM read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vga_bad_q <= 1'b0;
            vga_clr_q <= 1'b1;
        end else begin
            vga_bad_q <= !in_range(vga_cell_x, vga_cell_y);
            vga_clr_q <= (state_q == CTL_CLEAR);
        end
    end

    assign vga_cell_status = (vga_bad_q || vga_clr_q) ? ST_FREE
                                                      : sanitize(b_rdata);

    assign bus.ready = (state_q != CTL_CLEAR);
    assign bus.setup_ack = ack_any && (src_q == SRC_SETUP);
    assign bus.player_ack = ack_any && (src_q == SRC_PLAYER);
    assign bus.ia_ack = ack_any && (src_q == SRC_IA);
    assign bus.resp = resp_d;

endmodule

// File: tb/tb_board_status_ctrl.sv
// Directed bench for board_status_ctrl: sweep timing, RMW rules,
// arbitration, out-of-range handling, new_game and async reset.
module tb_board_status_ctrl;
    import board_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [3:0] vga_cell_x = 4'd0;
    logic [3:0] vga_cell_y = 4'd0;
    logic [4:0] vga_cell_status;
    int         checks = 0;
    int         failures = 0;

    board_status_ctrl_if bus();

    board_status_ctrl dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .vga_cell_x      (vga_cell_x),
        .vga_cell_y      (vga_cell_y),
        .vga_cell_status (vga_cell_status),
        .bus             (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int src, input logic req,
                         input logic [3:0] x, input logic [3:0] y);
        case (src)
            0: begin
                bus.setup_req = req; bus.setup_x = x; bus.setup_y = y;
            end
            1: begin
                bus.player_req = req; bus.player_x = x; bus.player_y = y;
            end
            default: begin
                bus.ia_req = req; bus.ia_x = x; bus.ia_y = y;
            end
        endcase
    endtask

    function automatic logic [2:0] acks();
        return {bus.setup_ack, bus.player_ack, bus.ia_ack};
    endfunction

    // One request from IDLE: ack expected on the first edge.
    task automatic do_op(input int src, input logic [3:0] x,
                         input logic [3:0] y, input logic [1:0] er,
                         input string tag);
        int n;
        logic [2:0] a;
        drive(src, 1'b1, x, y);
        n = 0;
        do begin
            tick();
            n++;
            a = acks();
        end while (a == 3'b000 && n < 8);
        check({tag, " ack"}, a, 3'b100 >> src);
        check({tag, " lat"}, n, 1);
        check({tag, " resp"}, bus.resp, er);
        drive(src, 1'b0, x, y);
        tick();
    endtask

    task automatic vga_rd(input logic [3:0] x, input logic [3:0] y,
                          input logic [4:0] exp, input string tag);
        vga_cell_x = x;
        vga_cell_y = y;
        tick();
        check(tag, vga_cell_status, exp);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 300) begin
            tick();
            n++;
        end
        check(tag, n, 100);
    endtask

    task automatic board_zero(input string tag);
        int bad;
        bad = 0;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                vga_cell_x = 4'(x);
                vga_cell_y = 4'(y);
                tick();
                if (vga_cell_status !== ST_FREE) bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.new_game = 1'b0;
        drive(0, 1'b0, 4'd0, 4'd0);
        drive(1, 1'b0, 4'd0, 4'd0);
        drive(2, 1'b0, 4'd0, 4'd0);
        repeat (2) tick();
        check("rst ready", bus.ready, 1'b0);
        check("rst acks", acks(), 3'b000);
        check("rst resp", bus.resp, RSP_MISS);
        check("rst vga", vga_cell_status, ST_FREE);

        rst_n_in = 1'b1;
        check("sweep ready0", bus.ready, 1'b0);
        wait_ready("sweep len");
        board_zero("sweep board");

        do_op(0, 4'd3, 4'd4, RSP_MISS, "setup34");
        vga_rd(4'd3, 4'd4, ST_OCC, "vga34 occ");
        do_op(0, 4'd3, 4'd4, RSP_REPEAT, "setup34 rep");

        do_op(1, 4'd3, 4'd4, RSP_HIT, "player34");
        vga_rd(4'd3, 4'd4, ST_PLAYER_HIT, "vga34 ph");
        check("resp hold", bus.resp, RSP_HIT);
        do_op(2, 4'd3, 4'd4, RSP_MISS, "ia34");
        vga_rd(4'd3, 4'd4, ST_BOTH_HIT, "vga34 both");
        do_op(2, 4'd3, 4'd4, RSP_REPEAT, "ia34 rep");

        drive(1, 1'b1, 4'd1, 4'd1);
        drive(2, 1'b1, 4'd2, 4'd2);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("rr%0d", i), acks(),
                  (i % 2 == 0) ? 3'b000 :
                  (i % 4 == 1) ? 3'b010 : 3'b001);
        end
        drive(0, 1'b1, 4'd5, 4'd5);
        tick();
        check("rr setup wins", acks(), 3'b100);
        check("rr setup resp", bus.resp, RSP_MISS);
        drive(0, 1'b0, 4'd5, 4'd5);
        drive(1, 1'b0, 4'd1, 4'd1);
        drive(2, 1'b0, 4'd2, 4'd2);
        tick();
        vga_rd(4'd1, 4'd1, ST_PLAYER_HIT, "vga11");
        vga_rd(4'd2, 4'd2, ST_IA_HIT, "vga22");
        vga_rd(4'd5, 4'd5, ST_OCC, "vga55");
        do_op(2, 4'd5, 4'd5, RSP_HIT, "ia55");
        vga_rd(4'd5, 4'd5, ST_IA_HIT, "vga55 ia");
        do_op(1, 4'd2, 4'd2, RSP_MISS, "player22");
        vga_rd(4'd2, 4'd2, ST_BOTH_HIT, "vga22 both");

        do_op(0, 4'd2, 4'd1, RSP_MISS, "setup21");
        do_op(1, 4'd10, 4'd2, RSP_BAD, "player bad x");
        do_op(1, 4'd3, 4'd10, RSP_BAD, "player bad y");
        vga_rd(4'd0, 4'd3, ST_FREE, "bad alias03");
        vga_rd(4'd10, 4'd2, ST_FREE, "vga oor 10,2");
        vga_rd(4'd12, 4'd0, ST_FREE, "vga oor 12,0");
        vga_rd(4'd2, 4'd1, ST_OCC, "vga21");

        drive(1, 1'b1, 4'd7, 4'd7);
        tick();
        bus.new_game = 1'b1;
        #1;
        check("ng no ack", acks(), 3'b000);
        tick();
        bus.new_game = 1'b0;
        drive(1, 1'b0, 4'd7, 4'd7);
        check("ng ready drop", bus.ready, 1'b0);
        wait_ready("ng sweep len");
        board_zero("ng board");

        do_op(0, 4'd4, 4'd4, RSP_MISS, "setup44");
        do_op(0, 4'd4, 4'd4, RSP_REPEAT, "setup44 rep");
        check("resp hold rep", bus.resp, RSP_REPEAT);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        repeat (50) tick();
        check("mid sweep ready", bus.ready, 1'b0);
        rst_n_in = 1'b0;
        #1;
        check("arst resp", bus.resp, RSP_MISS);
        check("arst vga", vga_cell_status, ST_FREE);
        tick();
        rst_n_in = 1'b1;
        check("arst ready0", bus.ready, 1'b0);
        wait_ready("arst sweep len");
        vga_rd(4'd4, 4'd4, ST_FREE, "arst vga44");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
